run_step_controller: RTL
========================

Name: run_step_controller

Overview:
- Sequences the CPU datapath by generating its clock-enable from the front-panel controls: step button, instruction/cycle switch, step/run switch and breakpoint enable.
- Sits between the board inputs and the datapath, in the oszClk domain.
- Stops the CPU cleanly at instruction boundaries, breakpoints and HALT.

Parameters:
- DEBOUNCE_CYCLES, 50000, clocks the synchronized step button must be stable before the new level is accepted (10 ms at 5 MHz).
- ADDR_WIDTH, 16, width of the PC and breakpoint address.

Ports:
- i_oszClk  in  1  design clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_btnStep  in  1  raw step button, 1 = pressed, asynchronous
- i_swInstrNCycle  in  1  1 = step one instruction, 0 = step one cycle, asynchronous
- i_swStepNRun  in  1  1 = step mode, 0 = free run, asynchronous
- i_swEnableBreakpoint  in  1  1 = breakpoint compare enabled, asynchronous
- i_breakpointAddress  in  ADDR_WIDTH  breakpoint PC
- i_pc  in  ADDR_WIDTH  current CPU program counter
- i_instrBoundary  in  1  1 = the next enabled cycle is microstep 0 (fetch) of a new instruction
- i_halt  in  1  1 = CPU is executing HALT in this cycle
- o_cpuClkEn  out  1  datapath clock enable
- o_halted  out  1  1 = CPU not advancing (state STOPPED)
- o_haltLatched  out  1  HALT has been executed since reset
- o_state  out  2  RUN=0, STOPPED=1, STEP_CYCLE=2, STEP_INSTR=3

Behaviour:
- Reset: state=STOPPED, o_cpuClkEn=0, o_halted=1, o_haltLatched=0, o_state=1. The bpArmed flag is set, the seenEn flag is cleared, the debounce counter is 0, and the debounced button level is 0.
- Synchronizers:
  - All four async inputs pass through a 2-FF synchronizer (2-cycle latency).
  - Debounce: a counter resets whenever the synced button differs from the debounced level. When it reaches DEBOUNCE_CYCLES-1 with the level still different, the debounced level takes the new value.
  - stepPulse is a one-cycle pulse on the debounced rising edge. Release generates nothing.
- o_cpuClkEn is combinational from registered state plus same-cycle i_pc / i_instrBoundary. This lets the CPU stop before the boundary cycle executes.
- bpHit = swEnableBreakpoint_s & bpArmed & i_instrBoundary & (i_pc == i_breakpointAddress).
- RUN:
  - o_cpuClkEn = ~bpHit.
  - Go to STOPPED if bpHit (and clear bpArmed), if swStepNRun_s=1, or if i_halt=1 in an enabled cycle (and set o_haltLatched).
- STOPPED:
  - o_cpuClkEn=0.
  - If o_haltLatched=1, stay here until reset; switches and button are ignored.
  - Else if swStepNRun_s=0, go to RUN. This has priority over stepPulse.
  - Else if stepPulse, go to STEP_CYCLE when swInstrNCycle_s=0, or to STEP_INSTR when it is 1. In both cases seenEn is cleared.
- STEP_CYCLE:
  - o_cpuClkEn=1 for exactly this one cycle, then go to STOPPED.
  - If i_halt=1, set o_haltLatched.
- STEP_INSTR:
  - o_cpuClkEn = ~(seenEn & i_instrBoundary); seenEn is set after the first enabled cycle.
  - Go to STOPPED on the cycle where the enable is suppressed, or after an enabled cycle with i_halt=1 (and set o_haltLatched).
  - Breakpoints are ignored here.
- bpArmed: set at the end of any cycle with o_cpuClkEn=1. Resuming from a breakpoint therefore executes the breakpoint instruction instead of re-halting.
- Switch changes take effect 2 cycles after the input edge. Flipping swStepNRun to 1 while in STEP_INSTR does not abort the step.
- Reset mid-operation: returns to STOPPED within the same clock edge and drops o_cpuClkEn the next cycle.
- o_halted = (state==STOPPED).

Test Plan (DEBOUNCE_CYCLES=4 in bench):
- Reset with swStepNRun=0 → o_state=1 during reset; 3 cycles after release o_state=0 and o_cpuClkEn=1 continuously.
- swStepNRun=1, single clean press of btnStep with swInstrNCycle=0 → exactly one o_cpuClkEn=1 cycle, 7 cycles after press (2 sync + 4 debounce + 1); a 2-cycle glitch pulse produces none.
- swInstrNCycle=1, instruction of 4 microsteps (i_instrBoundary high every 4th cycle), press step → exactly 4 enabled cycles; enable is low on the next boundary cycle; o_state returns to 1.
- RUN, breakpoint 16'h0042 enabled, i_pc reaches 0x0042 with i_instrBoundary=1 → o_cpuClkEn=0 in that same cycle, o_state=1. Toggling to step and back to run → CPU resumes and executes 0x0042 without a second stop.
- i_halt=1 during RUN → o_haltLatched=1, o_state=1. Later step presses and run switching give o_cpuClkEn=0 until i_reset.
- Assert i_reset during STEP_INSTR mid-instruction → o_cpuClkEn=0 the next cycle, o_state=1, o_haltLatched=0.

Source files
------------

// File: rtl/run_step_controller.sv
// run_step_controller: front-panel run/step/breakpoint/halt sequencing of the CPU clock enable
module run_step_controller #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  i_oszClk,
  input  logic                  i_reset,
  input  logic                  i_btnStep,
  input  logic                  i_swInstrNCycle,
  input  logic                  i_swStepNRun,
  input  logic                  i_swEnableBreakpoint,
  input  logic [ADDR_WIDTH-1:0] i_breakpointAddress,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic                  i_instrBoundary,
  input  logic                  i_halt,
  output logic                  o_cpuClkEn,
  output logic                  o_halted,
  output logic                  o_haltLatched,
  output logic [1:0]            o_state
);
  typedef enum logic [1:0] {RUN = 2'd0, STOPPED = 2'd1, STEP_CYCLE = 2'd2, STEP_INSTR = 2'd3} state_t;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] btnSync, instrSync, stepSync, bpSync;
  logic btnS, instrS, stepNRunS, bpEnS;
  logic [CW-1:0] dbCnt;
  logic btnLevel, stepPulse;
  state_t state, stateNext;
  logic bpArmed, bpArmedNext, seenEn, seenEnNext, haltLatched, haltLatchedNext;
  logic bpHit, cpuClkEn;
  // Synchronizers are left unreset so they already track the switches when reset releases
  always_ff @(posedge i_oszClk) begin
    btnSync   <= {btnSync[0], i_btnStep};
    instrSync <= {instrSync[0], i_swInstrNCycle};
    stepSync  <= {stepSync[0], i_swStepNRun};
    bpSync    <= {bpSync[0], i_swEnableBreakpoint};
  end
  assign btnS      = btnSync[1];
  assign instrS    = instrSync[1];
  assign stepNRunS = stepSync[1];
  assign bpEnS     = bpSync[1];
  always_ff @(posedge i_oszClk) begin
    if (i_reset) begin
      dbCnt    <= '0;
      btnLevel <= 1'b0;
    end else if (btnS == btnLevel) begin
      dbCnt <= '0;
    end else if (dbCnt == CNT_MAX) begin
      dbCnt    <= '0;
      btnLevel <= btnS;
    end else begin
      dbCnt <= dbCnt + 1'b1;
    end
  end
  assign stepPulse = btnS & ~btnLevel & (dbCnt == CNT_MAX);
  assign bpHit = bpEnS & bpArmed & i_instrBoundary & (i_pc == i_breakpointAddress);
  // Enable looks at the current pc/boundary so a stop lands before the boundary cycle executes
  assign cpuClkEn = (state == RUN)        ? ~bpHit :
                    (state == STEP_CYCLE) ? 1'b1 :
                    (state == STEP_INSTR) ? ~(seenEn & i_instrBoundary) : 1'b0;
  always_comb begin
    stateNext       = state;
    bpArmedNext     = (bpArmed | cpuClkEn) & ~(bpHit & (state == RUN));
    seenEnNext      = seenEn | cpuClkEn;
    haltLatchedNext = haltLatched | (cpuClkEn & i_halt);
    case (state)
      RUN:        stateNext = (bpHit | stepNRunS | i_halt) ? STOPPED : RUN;
      STOPPED: begin
        if (!haltLatched && !stepNRunS) stateNext = RUN;
        else if (!haltLatched && stepPulse) begin
          stateNext  = instrS ? STEP_INSTR : STEP_CYCLE;
          seenEnNext = 1'b0;
        end
      end
      STEP_CYCLE: stateNext = STOPPED;
      STEP_INSTR: stateNext = (!cpuClkEn || i_halt) ? STOPPED : STEP_INSTR;
    endcase
  end
  always_ff @(posedge i_oszClk) begin
    if (i_reset) begin
      state       <= STOPPED;
      bpArmed     <= 1'b1;
      seenEn      <= 1'b0;
      haltLatched <= 1'b0;
    end else begin
      state       <= stateNext;
      bpArmed     <= bpArmedNext;
      seenEn      <= seenEnNext;
      haltLatched <= haltLatchedNext;
    end
  end
  assign o_cpuClkEn    = cpuClkEn;
  assign o_halted      = (state == STOPPED);
  assign o_haltLatched = haltLatched;
  assign o_state       = state;
endmodule
